// File: rtl/clkgen_pkg.sv
// Shared definitions for the multiphase clock generator.
// Contents:
//   state_t      - sequencer states IDLE / ACTIVE / GAP
//   DIV_W_DEF    - default width of the phase-width input
//   GAP_W_DEF    - default width of the dead-time input
//   norm_div()   - maps a programmed phase width of 0 onto 1
package clkgen_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int GAP_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    // A phase is never shorter than one clock, so width 0 is treated as 1.
    function automatic logic [31:0] norm_div(input logic [31:0] d);
        if (d == 32'd0) begin
            return 32'd1;
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/multiphase_clkgen_phase_timer.sv
// phase_timer: loadable down-counter used to time phase and dead-time spans.
// Ports:
//   clock    - system clock, rising edge
//   reset_n  - asynchronous active-low reset, clears the count
//   load     - load load_val on the next edge (takes priority over tick)
//   load_val - value to load; the span lasts load_val+1 ticks
//   tick     - count down by one (saturates at zero)
//   tc       - terminal count, high while the count is zero
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    // Down-counter: load has priority, otherwise decrement until zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (tick && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/multiphase_clkgen.sv
// multiphase_clkgen: one-hot, non-overlapping phase strobe generator.
// Ports:
//   clock      - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   enable     - run request; only looked at in IDLE and at rotation wrap
//   div        - clocks each phase is held high (0 treated as 1)
//   gap        - all-low dead-time clocks between phases (0 = none)
//   phase      - one-hot phase strobes, registered
//   phase_idx  - index of the current or most recent phase, registered
//   busy       - high while the sequencer is not IDLE, registered
//   cycle_done - one-clock pulse in the first cycle after a full rotation
module multiphase_clkgen
    import clkgen_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int GAP_W      = GAP_W_DEF,
    parameter int IDX_W      = $clog2(NUM_PHASES)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      div,
    input  logic [GAP_W-1:0]      gap,
    output logic [NUM_PHASES-1:0] phase,
    output logic [IDX_W-1:0]      phase_idx,
    output logic                  busy,
    output logic                  cycle_done
);

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] ONE_HOT0  = NUM_PHASES'(1);

    state_t                  state_r, state_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [DIV_W-1:0]        div_q_r, div_sel_s;
    logic [GAP_W-1:0]        gap_q_r, gap_sel_s;
    logic [NUM_PHASES-1:0]   phase_r, phase_s;
    logic                    busy_r, done_r;
    logic                    latch_s, adv_s, done_s;
    logic                    load_act_s, load_gap_s, tick_act_s, tick_gap_s;
    logic                    act_tc_s, gap_tc_s;

    // Next-state logic; advancing past the last phase is the only place
    // (besides leaving IDLE) where enable is honoured and div/gap relatched.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        latch_s    = 1'b0;
        adv_s      = 1'b0;
        done_s     = 1'b0;
        load_act_s = 1'b0;
        load_gap_s = 1'b0;
        tick_act_s = 1'b0;
        tick_gap_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s    = ACTIVE;
                    idx_s      = {IDX_W{1'b0}};
                    latch_s    = 1'b1;
                    load_act_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (act_tc_s) begin
                    if (gap_q_r != {GAP_W{1'b0}}) begin
                        state_s    = GAP;
                        load_gap_s = 1'b1;
                    end else begin
                        adv_s = 1'b1;
                    end
                end else begin
                    tick_act_s = 1'b1;
                end
            end
            GAP: begin
                if (gap_tc_s) begin
                    adv_s = 1'b1;
                end else begin
                    tick_gap_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = {IDX_W{1'b0}};
            end
        endcase

        if (adv_s) begin
            if (idx_r == LAST_IDX) begin
                done_s = 1'b1;
                if (enable) begin
                    state_s    = ACTIVE;
                    idx_s      = {IDX_W{1'b0}};
                    latch_s    = 1'b1;
                    load_act_s = 1'b1;
                end else begin
                    // Stop; phase_idx keeps pointing at the final phase.
                    state_s = IDLE;
                end
            end else begin
                state_s    = ACTIVE;
                idx_s      = idx_r + IDX_W'(1);
                load_act_s = 1'b1;
            end
        end else begin
            done_s = 1'b0;
        end
    end

    // Freshly sampled div/gap are used for the very load that latches them.
    always_comb begin
        div_sel_s = div_q_r;
        gap_sel_s = gap_q_r;
        if (latch_s) begin
            div_sel_s = DIV_W'(norm_div(32'(div)));
            gap_sel_s = gap;
        end else begin
            div_sel_s = div_q_r;
            gap_sel_s = gap_q_r;
        end
    end

    // Output decode from the next state so the strobes come straight off flops.
    always_comb begin
        phase_s = {NUM_PHASES{1'b0}};
        if (state_s == ACTIVE) begin
            phase_s = ONE_HOT0 << idx_s;
        end else begin
            phase_s = {NUM_PHASES{1'b0}};
        end
    end

    phase_timer #(.W(DIV_W)) u_act_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load_act_s),
        .load_val (div_sel_s - DIV_W'(1)),
        .tick     (tick_act_s),
        .tc       (act_tc_s)
    );

    phase_timer #(.W(GAP_W)) u_gap_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load_gap_s),
        .load_val (gap_q_r - GAP_W'(1)),
        .tick     (tick_gap_s),
        .tc       (gap_tc_s)
    );

    // Sequencer state, latched settings and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            div_q_r <= {DIV_W{1'b0}};
            gap_q_r <= {GAP_W{1'b0}};
            phase_r <= {NUM_PHASES{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            div_q_r <= div_sel_s;
            gap_q_r <= gap_sel_s;
            phase_r <= phase_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= done_s;
        end
    end

    assign phase      = phase_r;
    assign phase_idx  = idx_r;
    assign busy       = busy_r;
    assign cycle_done = done_r;

endmodule

// File: tb/tb_multiphase_clkgen.sv
// Directed testbench for multiphase_clkgen: a 4-phase instance for the
// timing, stop and reset scenarios and a 6-phase instance for wrap/one-hot.
module tb_multiphase_clkgen;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic [7:0] div;
    logic [3:0] gap;
    logic [3:0] phase;
    logic [1:0] phase_idx;
    logic       busy;
    logic       cycle_done;

    logic       enable6;
    logic [7:0] div6;
    logic [3:0] gap6;
    logic [5:0] phase6;
    logic [2:0] phase_idx6;
    logic       busy6;
    logic       cycle_done6;

    int checks;
    int errors;

    multiphase_clkgen #(.NUM_PHASES(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .div        (div),
        .gap        (gap),
        .phase      (phase),
        .phase_idx  (phase_idx),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    multiphase_clkgen #(.NUM_PHASES(6)) dut6 (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable6),
        .div        (div6),
        .gap        (gap6),
        .phase      (phase6),
        .phase_idx  (phase_idx6),
        .busy       (busy6),
        .cycle_done (cycle_done6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int p;
        int k;
        int r;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        div     = 8'd1;
        gap     = 4'd0;
        enable6 = 1'b0;
        div6    = 8'd2;
        gap6    = 4'd0;

        // Reset state.
        tick();
        tick();
        check_eq("rst_phase", 32'(phase), 32'd0);
        check_eq("rst_idx", 32'(phase_idx), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(cycle_done), 32'd0);
        reset_n = 1'b1;
        tick();
        check_eq("idle_phase", 32'(phase), 32'd0);

        // Defaults div=1 gap=0; enable rises at cycle 0, dropped during phase 1
        // of the fourth rotation.
        enable = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            k = (c - 1) % 4;
            check_eq("def_phase", 32'(phase), 32'd1 << k);
            check_eq("def_idx", 32'(phase_idx), 32'(k));
            check_eq("def_busy", 32'(busy), 32'd1);
            check_eq("def_done", 32'(cycle_done), (c == 5 || c == 9 || c == 13) ? 32'd1 : 32'd0);
        end
        enable = 1'b0;
        tick();
        check_eq("stop_ph2", 32'(phase), 32'd4);
        tick();
        check_eq("stop_ph3", 32'(phase), 32'd8);
        check_eq("stop_busy3", 32'(busy), 32'd1);
        tick();
        check_eq("stop_done", 32'(cycle_done), 32'd1);
        check_eq("stop_phase", 32'(phase), 32'd0);
        check_eq("stop_busy", 32'(busy), 32'd0);
        check_eq("stop_idx", 32'(phase_idx), 32'd3);
        tick();
        check_eq("stop_done_off", 32'(cycle_done), 32'd0);
        check_eq("stop_idle_phase", 32'(phase), 32'd0);
        check_eq("stop_idle_idx", 32'(phase_idx), 32'd3);

        // div=3 gap=2: 3 high + 2 low per phase, 20-clock rotation.
        div    = 8'd3;
        gap    = 4'd2;
        enable = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            tick();
            p = (c - 1) % 20;
            k = p / 5;
            r = p % 5;
            check_eq("dg_phase", 32'(phase), (r < 3) ? (32'd1 << k) : 32'd0);
            check_eq("dg_idx", 32'(phase_idx), 32'(k));
            check_eq("dg_busy", 32'(busy), 32'd1);
            check_eq("dg_done", 32'(cycle_done), (c == 21 || c == 41) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset in the middle of phase 2, between edges.
        #2;
        reset_n = 1'b0;
        div     = 8'd0;
        gap     = 4'd0;
        #1;
        check_eq("arst_phase", 32'(phase), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_idx", 32'(phase_idx), 32'd0);
        check_eq("arst_done", 32'(cycle_done), 32'd0);
        reset_n = 1'b1;

        // div=0 acts as div=1; div raised to 5 during phase 2 applies only
        // from the next rotation.
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c < 5) begin
                k = c - 1;
            end else begin
                k = ((c - 5) % 20) / 5;
            end
            check_eq("d0_phase", 32'(phase), 32'd1 << k);
            check_eq("d0_idx", 32'(phase_idx), 32'(k));
            check_eq("d0_done", 32'(cycle_done), (c == 5 || c == 25) ? 32'd1 : 32'd0);
            if (c == 3) begin
                div = 8'd5;
            end
        end

        // Park the 4-phase instance and run the 6-phase one with div=2.
        enable  = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        enable6 = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            p = (c - 1) % 12;
            k = p / 2;
            check_eq("p6_onehot", 32'($countones(phase6)), 32'd1);
            check_eq("p6_phase", 32'(phase6), 32'd1 << k);
            check_eq("p6_idx", 32'(phase_idx6), 32'(k));
            check_eq("p6_done", 32'(cycle_done6), (c == 13 || c == 25) ? 32'd1 : 32'd0);
            check_eq("p4_parked", 32'(phase), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
